// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI flash read path.
package qspi_pkg;

    localparam logic [7:0] QSPI_CMD_QOFR = 8'h6B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_RESP,
        ST_WAIT_NEXT
    } qspi_rd_state_t;

    // {IO3, IO2, IO1, IO0} = {hold, wp, so, si}
    typedef logic [3:0] qspi_nibble_t;

    function automatic int qspi_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/qspi_pin_drv.sv
// Tristate drivers for the QSPI IO lines and the raw input nibble they present.
module qspi_pin_drv
    import qspi_pkg::*;
(
    input  logic         oe_i,
    input  logic         si_o_i,
    output qspi_nibble_t nib_o,
    inout  wire          si,
    inout  wire          so,
    inout  wire          wp,
    inout  wire          hold
);

    // wp/hold are held inactive while this block owns the bus; IO1 stays an input.
    assign si   = oe_i ? si_o_i : 1'bz;
    assign wp   = oe_i ? 1'b1   : 1'bz;
    assign hold = oe_i ? 1'b1   : 1'bz;

    assign nib_o = {hold, wp, so, si};

endmodule

// File: rtl/qspi_flash_reader.sv
// Quad Output Fast Read (0x6B) initiator: one 32-bit little-endian word per request,
// with cs held low across sequential addresses to skip the cmd/addr phases.
module qspi_flash_reader
    import qspi_pkg::*;
#(
    parameter int ADDR_WIDTH   = 24,
    parameter int DUMMY_CYCLES = 8,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CS_HIGH_MIN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic                  cs,
    output logic                  sclk,
    inout  wire                   si,
    inout  wire                   so,
    inout  wire                   wp,
    inout  wire                   hold
);

    localparam int SH_W    = 8 + ADDR_WIDTH;
    localparam int CNT_MAX = qspi_max(qspi_max(ADDR_WIDTH, DUMMY_CYCLES),
                                      qspi_max(IDLE_TIMEOUT, qspi_max(CS_HIGH_MIN, 8)));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CS_MIN_M1 = CNT_W'(CS_HIGH_MIN - 1);
    localparam logic [CNT_W-1:0] TMO_M1    = CNT_W'(IDLE_TIMEOUT - 1);

    qspi_rd_state_t        state_q, state_d, phase_next;
    logic [CNT_W-1:0]      cnt_q, cnt_d, phase_last;
    logic                  cs_q, cs_d, sclk_q, sclk_d;
    logic [SH_W-1:0]       sh_out_q, sh_out_d;
    logic [31:0]           sh_in_q, sh_in_d;
    logic [ADDR_WIDTH-1:0] addr_nxt_q, addr_nxt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic [ADDR_WIDTH-1:0] req_addr_w;
    logic                  seq_hit;
    logic                  drv_oe;
    qspi_nibble_t          nib;

    assign req_addr_w = req_addr & ~ADDR_WIDTH'(3);
    assign seq_hit    = (req_addr_w == addr_nxt_q);
    assign drv_oe     = (state_q == ST_CMD) || (state_q == ST_ADDR);

    qspi_pin_drv u_pin_drv (
        .oe_i   (drv_oe),
        .si_o_i (sh_out_q[SH_W-1]),
        .nib_o  (nib),
        .si     (si),
        .so     (so),
        .wp     (wp),
        .hold   (hold)
    );

    always_comb begin
        phase_last = CNT_W'(7);
        phase_next = state_q;
        case (state_q)
            ST_CMD:   phase_next = ST_ADDR;
            ST_ADDR: begin
                phase_last = CNT_W'(ADDR_WIDTH - 1);
                phase_next = (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
            end
            ST_DUMMY: begin
                phase_last = CNT_W'(DUMMY_CYCLES - 1);
                phase_next = ST_DATA;
            end
            ST_DATA:  phase_next = ST_RESP;
            default:  ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cs_d         = cs_q;
        sclk_d       = sclk_q;
        sh_out_d     = sh_out_q;
        sh_in_d      = sh_in_q;
        addr_nxt_d   = addr_nxt_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        req_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // cnt_q counts cs-high cycles here, saturating at the minimum
                if (cnt_q < CS_MIN_M1) cnt_d = cnt_q + CNT_W'(1);
                req_ready = !rst && !resp_valid_q && (cnt_q >= CS_MIN_M1);
                if (req_ready && req_valid) begin
                    state_d    = ST_CMD;
                    cnt_d      = '0;
                    cs_d       = 1'b0;
                    sclk_d     = 1'b0;
                    sh_out_d   = {QSPI_CMD_QOFR, req_addr_w};
                    addr_nxt_d = req_addr_w + ADDR_WIDTH'(4);
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                sclk_d = !sclk_q;
                // a bit completes on the edge that ends its high half
                if (sclk_q) begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    sh_out_d = sh_out_q << 1;
                    if (state_q == ST_DATA) sh_in_d = {sh_in_q[27:0], nib};
                    if (cnt_q == phase_last) begin
                        cnt_d   = '0;
                        state_d = phase_next;
                    end
                end
            end
            ST_RESP: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = {sh_in_q[7:0], sh_in_q[15:8], sh_in_q[23:16], sh_in_q[31:24]};
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_WAIT_NEXT;
                    cnt_d        = '0;
                end
            end
            ST_WAIT_NEXT: begin
                req_ready = !rst && !resp_valid_q && !(req_valid && !seq_hit);
                if (req_valid && seq_hit) begin
                    state_d    = ST_DATA;
                    cnt_d      = '0;
                    addr_nxt_d = addr_nxt_q + ADDR_WIDTH'(4);
                end else if (req_valid || (cnt_q == TMO_M1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CS_MIN_M1;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cs_q         <= cs_d;
            sclk_q       <= sclk_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
        sh_out_q   <= sh_out_d;
        sh_in_q    <= sh_in_d;
        addr_nxt_q <= addr_nxt_d;
    end

    assign cs         = cs_q;
    assign sclk       = sclk_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Randomized bench for qspi_flash_reader with a behavioural flash and transaction model.
`timescale 1ns/1ps
module tb_qspi_flash_reader;

    localparam int AW  = 24;
    localparam int DC  = 8;
    localparam int TMO = 16;
    localparam int CSM = 4;
    localparam int COLD_LAT = (8 + AW + DC + 8) * 2 + 1;
    localparam int SEQ_LAT  = 8 * 2 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          resp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          req_ready, resp_valid, cs, sclk;
    logic [31:0]   resp_data;
    wire           si, so, wp, hold;

    int n_chk = 0;
    int n_fail = 0;

    qspi_flash_reader #(
        .ADDR_WIDTH(AW), .DUMMY_CYCLES(DC), .IDLE_TIMEOUT(TMO), .CS_HIGH_MIN(CSM)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .cs(cs), .sclk(sclk), .si(si), .so(so), .wp(wp), .hold(hold)
    );

    always #5 clk = ~clk;

    // Flash contents: fixed pattern at 0..3, hashed bytes elsewhere.
    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        case (a)
            24'h000000: return 8'h37;
            24'h000001: return 8'h00;
            24'h000002: return 8'h00;
            24'h000003: return 8'hAB;
            default:    return a[7:0] ^ (a[15:8] * 8'd13) ^ a[23:16] ^ 8'hC3;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
    endfunction

    // Flash device: samples cmd/addr on rising sclk, shifts out nibbles on falling sclk.
    logic          mk_en = 1'b0;
    logic [3:0]    mk_nib = '0;
    int            mk_bits = 0;
    int            mk_d;
    logic [7:0]    mk_cmd = '0;
    logic [AW-1:0] mk_addr = '0;
    logic [7:0]    mk_b;

    assign si   = mk_en ? mk_nib[0] : 1'bz;
    assign so   = mk_en ? mk_nib[1] : 1'bz;
    assign wp   = mk_en ? mk_nib[2] : 1'bz;
    assign hold = mk_en ? mk_nib[3] : 1'bz;

    always @(posedge sclk or negedge sclk or posedge cs) begin
        if (cs) begin
            mk_bits = 0;
            mk_en   = 1'b0;
        end else if (sclk) begin
            if (mk_bits < 8) mk_cmd = {mk_cmd[6:0], si};
            else if (mk_bits < 8 + AW) mk_addr = {mk_addr[AW-2:0], si};
            mk_bits++;
        end else if (mk_bits >= 8 + AW + DC) begin
            mk_d   = mk_bits - (8 + AW + DC);
            mk_b   = mem_byte(mk_addr + 24'(mk_d / 2));
            mk_nib = (mk_d % 2 == 1) ? mk_b[3:0] : mk_b[7:4];
            mk_en  = 1'b1;
        end
    end

    int cs_hi_run = 0;
    int cs_hi_last = 0;
    int cs_rises = 0;
    always @(negedge clk) begin
        if (cs) cs_hi_run++;
        else begin
            if (cs_hi_run > 0) cs_hi_last = cs_hi_run;
            cs_hi_run = 0;
        end
    end
    always @(posedge cs) cs_rises++;

    // Transaction-level model: is a cs-low window open, and what address continues it.
    bit            model_open = 1'b0;
    logic [AW-1:0] model_next = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        if (n > TMO + 2) model_open = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int stall);
        logic [AW-1:0] aw;
        logic [31:0]   exp;
        int            exp_lat, cyc, lat, rises0;
        bit            seq, ok;
        aw      = a & ~24'd3;
        seq     = model_open && (aw == model_next);
        exp_lat = seq ? SEQ_LAT : COLD_LAT;
        exp     = word_at(aw);
        rises0  = cs_rises;
        req_valid = 1'b1;
        req_addr  = {a[AW-1:2], 2'($urandom)};
        #1;
        if (model_open && !seq) check("nonseq_ready_low", req_ready, 0);
        cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_wait", cyc < 200, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("data", resp_data, exp);
        if (seq) check("cs_window_kept", cs_rises - rises0, 0);
        else begin
            check("cmd_byte", mk_cmd, 8'h6B);
            check("addr_sent", mk_addr, aw);
            check("cs_high_min", cs_hi_last >= CSM, 1);
        end
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== exp || sclk || cs || req_ready) ok = 1'b0;
        end
        if (stall > 0) check("stall_hold", ok, 1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_drop", resp_valid, 0);
        model_open = 1'b1;
        model_next = aw + 24'd4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [AW-1:0] a;
        int            r, gap, cyc;
        bit            ok;

        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        do_read(24'h000000, 0);
        check("cold_word0", resp_data, 32'hAB000037);

        idle(30);
        do_read(24'h000010, 0);
        do_read(24'h000014, 0);
        do_read(24'h000018, 0);
        do_read(24'h000040, 0);

        idle(30);
        do_read(24'hFFFFFC, 0);
        do_read(24'h000000, 0);
        check("wrap_word0", resp_data, 32'hAB000037);

        do_read(24'h000004, 20);

        idle(30);
        check("timeout_cs_high", cs, 1);
        do_read(24'h000008, 0);

        // reset while the address is being shifted out
        idle(30);
        req_valid = 1'b1;
        req_addr  = 24'h123454;
        cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("addr_phase_cs_low", cs, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cs", cs, 1);
        check("midrst_sclk", sclk, 0);
        check("midrst_ready", req_ready, 0);
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (resp_valid || !cs) ok = 1'b0;
        end
        check("midrst_no_resp", ok, 1);
        model_open = 1'b0;
        do_read(24'h123454, 0);

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      a = 24'($urandom);
            else if (r == 1) a = 24'hFFFFF0 + 24'($urandom_range(0, 15));
            else             a = model_next;
            gap = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 8) : $urandom_range(30, 40);
            idle(gap);
            do_read(a, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
